common_pipeline_buffer: RTL and testbench

COMMON_PIPELINE_BUFFER -- requirements
Module: common_pipeline_buffer

---
 rtl/common_pipeline_buffer.sv | 83 ++++++++
 tb/tb_common_pipeline_buffer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/common_pipeline_buffer.sv
// Two-entry fully registered pipeline buffer (main + skid) with valid/ready on both sides.
// Every output comes straight from a flop, so no input reaches an output combinationally.
module common_pipeline_buffer #(
  parameter int BUFFER_WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BUFFER_WIDTH-1:0] prev_i_data,
  input  logic                    prev_i_valid,
  output logic                    prev_o_ready,
  output logic [BUFFER_WIDTH-1:0] next_o_data,
  output logic                    next_o_valid,
  input  logic                    next_i_ready,
  output logic [1:0]              buffer_o_count
);

  // Handshake: a beat moves on a rising edge when valid and ready are both high
  // in that cycle; a sender holds data and valid steady until it is accepted.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                  state;
  logic [BUFFER_WIDTH-1:0] main_q;
  logic [BUFFER_WIDTH-1:0] skid_q;
  logic                    push;
  logic                    pop;

  assign push           = prev_i_valid & prev_o_ready;
  assign pop            = next_o_valid & next_i_ready;
  assign next_o_data    = main_q;
  // The state encoding equals the occupancy, so the count doubles as the FSM state view.
  assign buffer_o_count = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= EMPTY;
      main_q       <= '0;
      skid_q       <= '0;
      next_o_valid <= 1'b0;
      prev_o_ready <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            main_q       <= prev_i_data;
            state        <= ONE;
            next_o_valid <= 1'b1;
            prev_o_ready <= 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_q <= prev_i_data;
          end else if (push) begin
            // Downstream stalled: park the new beat in the skid and stop accepting.
            skid_q       <= prev_i_data;
            state        <= TWO;
            prev_o_ready <= 1'b0;
          end else if (pop) begin
            state        <= EMPTY;
            next_o_valid <= 1'b0;
          end
        end
        TWO: begin
          if (pop) begin
            main_q       <= skid_q;
            state        <= ONE;
            prev_o_ready <= 1'b1;
          end
        end
        default: begin
          state        <= EMPTY;
          next_o_valid <= 1'b0;
          prev_o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_common_pipeline_buffer.sv
// Directed checks of the pipeline buffer at width 8, followed by a short random
// valid/ready run checked against an expected queue.
module tb_common_pipeline_buffer;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic [W-1:0] prev_i_data;
  logic         prev_i_valid;
  logic         prev_o_ready;
  logic [W-1:0] next_o_data;
  logic         next_o_valid;
  logic         next_i_ready;
  logic [1:0]   buffer_o_count;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  common_pipeline_buffer #(.BUFFER_WIDTH(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .prev_i_data    (prev_i_data),
    .prev_i_valid   (prev_i_valid),
    .prev_o_ready   (prev_o_ready),
    .next_o_data    (next_o_data),
    .next_o_valid   (next_o_valid),
    .next_i_ready   (next_i_ready),
    .buffer_o_count (buffer_o_count)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs, take one rising edge, then settle 1ns past it for sampling.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r);
    prev_i_valid = v;
    prev_i_data  = d;
    next_i_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic rdy,
                           input logic [1:0] cnt, input logic [W-1:0] d);
    check({tag, ".valid"}, {31'd0, next_o_valid}, {31'd0, v});
    check({tag, ".ready"}, {31'd0, prev_o_ready}, {31'd0, rdy});
    check({tag, ".count"}, {30'd0, buffer_o_count}, {30'd0, cnt});
    if (v) check({tag, ".data"}, {24'd0, next_o_data}, {24'd0, d});
  endtask

  initial begin
    reset        = 1'b0;
    prev_i_valid = 1'b0;
    prev_i_data  = '0;
    next_i_ready = 1'b0;

    // Reset takes effect with no clock edge
    #2 reset = 1'b1;
    #1;
    check_out("reset", 1'b0, 1'b1, 2'd0, 8'h00);
    check("reset.data", {24'd0, next_o_data}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // First push accepted on the first edge after deassertion, one cycle latency
    step(1'b1, 8'hA5, 1'b1);
    check_out("single", 1'b1, 1'b1, 2'd1, 8'hA5);
    step(1'b0, 8'h00, 1'b1);
    check_out("single_drain", 1'b0, 1'b1, 2'd0, 8'h00);

    // Streaming at full rate
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, W'(i), 1'b1);
      check_out($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, W'(i));
    end
    step(1'b0, 8'h00, 1'b1);
    check_out("stream_drain", 1'b0, 1'b1, 2'd0, 8'h00);

    // Backpressure fills the skid; 0x33 is refused while full
    step(1'b1, 8'h11, 1'b0);
    check_out("bp_one", 1'b1, 1'b1, 2'd1, 8'h11);
    step(1'b1, 8'h22, 1'b0);
    check_out("bp_two", 1'b1, 1'b0, 2'd2, 8'h11);
    step(1'b1, 8'h33, 1'b0);
    check_out("bp_hold", 1'b1, 1'b0, 2'd2, 8'h11);
    step(1'b1, 8'h33, 1'b1);
    check_out("bp_pop1", 1'b1, 1'b1, 2'd1, 8'h22);
    step(1'b1, 8'h33, 1'b1);
    check_out("bp_pop2", 1'b1, 1'b1, 2'd1, 8'h33);
    step(1'b0, 8'h00, 1'b1);
    check_out("bp_drain", 1'b0, 1'b1, 2'd0, 8'h00);

    // Push and pop together while holding one entry
    step(1'b1, 8'h40, 1'b0);
    check_out("pp_load", 1'b1, 1'b1, 2'd1, 8'h40);
    step(1'b1, 8'h41, 1'b1);
    check_out("pp_swap", 1'b1, 1'b1, 2'd1, 8'h41);
    step(1'b0, 8'h00, 1'b0);
    check_out("pp_hold", 1'b1, 1'b1, 2'd1, 8'h41);
    step(1'b0, 8'h00, 1'b1);
    check_out("pp_drain", 1'b0, 1'b1, 2'd0, 8'h00);

    // Reset while full discards everything
    step(1'b1, 8'h77, 1'b0);
    step(1'b1, 8'h88, 1'b0);
    check_out("mid_full", 1'b1, 1'b0, 2'd2, 8'h77);
    #2 reset = 1'b1;
    #1;
    check_out("mid_reset", 1'b0, 1'b1, 2'd0, 8'h00);
    check("mid_reset.data", {24'd0, next_o_data}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1);
      check_out($sformatf("post_reset%0d", i), 1'b0, 1'b1, 2'd0, 8'h00);
    end
    step(1'b1, 8'h99, 1'b1);
    check_out("post_reset_push", 1'b1, 1'b1, 2'd1, 8'h99);
    step(1'b0, 8'h00, 1'b1);
    check_out("post_reset_drain", 1'b0, 1'b1, 2'd0, 8'h00);

    // Random valid/ready traffic against the expected queue
    for (int c = 0; c < 300; c++) begin
      logic         v;
      logic         r;
      logic [W-1:0] d;
      logic         do_push;
      logic         do_pop;
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      d = W'($urandom_range(0, 255));
      check("rnd.valid", {31'd0, next_o_valid}, {31'd0, exp_q.size() != 0});
      check("rnd.ready", {31'd0, prev_o_ready}, {31'd0, exp_q.size() < 2});
      check("rnd.count", {30'd0, buffer_o_count}, 32'(exp_q.size()));
      if (exp_q.size() != 0) check("rnd.data", {24'd0, next_o_data}, {24'd0, exp_q[0]});
      do_push = v && (exp_q.size() < 2);
      do_pop  = r && (exp_q.size() != 0);
      step(v, d, r);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
